// File: rtl/pll_cfg_seq.sv
// Divider/enable sequencer for the PLL configuration struct: loads new dividers only
// while the PLL is powered down, then re-enables it and qualifies lock with a timeout.
module pll_cfg_seq #(
    parameter int unsigned OFF_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 8,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic [9:0]  cfg_ratio_i,
    input  logic [23:0] cfg_fraction_i,
    input  logic [5:0]  cfg_mdiv_i,
    input  logic [1:0]  cfg_vcodiv_i,
    input  logic [9:0]  cfg_zdiv0_i,
    input  logic        cfg_zdiv0_p5_i,
    input  logic [9:0]  cfg_zdiv1_i,
    input  logic        cfg_zdiv1_p5_i,
    input  logic        lock_i,
    output logic        pllen_o,
    output logic        bypass_o,
    output logic [9:0]  ratio_o,
    output logic [23:0] fraction_o,
    output logic [5:0]  mdiv_o,
    output logic [1:0]  vcodiv_o,
    output logic [9:0]  zdiv0_o,
    output logic        zdiv0_p5_o,
    output logic [9:0]  zdiv1_o,
    output logic        zdiv1_p5_o,
    output logic        busy_o,
    output logic        locked_o,
    output logic        done_o,
    output logic        err_cfg_o,
    output logic        err_timeout_o,
    output logic        err_lol_o
);

    localparam int unsigned OffW  = $clog2(OFF_CYCLES + 1);
    localparam int unsigned StabW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned ToW   = $clog2(LOCK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StPwrDown,
        StLoad,
        StPwrUp,
        StLocked,
        StError
    } state_e;

    state_e state_q;

    logic lock_meta_q, lock_s;

    logic [OffW-1:0]  off_cnt_q;
    logic [StabW-1:0] stab_cnt_q;
    logic [ToW-1:0]   to_cnt_q;

    logic [9:0]  sh_ratio_q;
    logic [23:0] sh_fraction_q;
    logic [5:0]  sh_mdiv_q;
    logic [1:0]  sh_vcodiv_q;
    logic [9:0]  sh_zdiv0_q;
    logic        sh_zdiv0_p5_q;
    logic [9:0]  sh_zdiv1_q;
    logic        sh_zdiv1_p5_q;

    logic accepting, cfg_valid;

    assign accepting = (state_q == StIdle) || (state_q == StLocked) || (state_q == StError);
    assign cfg_valid = (cfg_ratio_i != '0) && (cfg_mdiv_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_meta_q <= 1'b0;
            lock_s      <= 1'b0;
        end else begin
            lock_meta_q <= lock_i;
            lock_s      <= lock_meta_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            off_cnt_q     <= '0;
            stab_cnt_q    <= '0;
            to_cnt_q      <= '0;
            sh_ratio_q    <= '0;
            sh_fraction_q <= '0;
            sh_mdiv_q     <= '0;
            sh_vcodiv_q   <= '0;
            sh_zdiv0_q    <= '0;
            sh_zdiv0_p5_q <= 1'b0;
            sh_zdiv1_q    <= '0;
            sh_zdiv1_p5_q <= 1'b0;
            pllen_o       <= 1'b0;
            bypass_o      <= 1'b1;
            ratio_o       <= '0;
            fraction_o    <= '0;
            mdiv_o        <= '0;
            vcodiv_o      <= '0;
            zdiv0_o       <= '0;
            zdiv0_p5_o    <= 1'b0;
            zdiv1_o       <= '0;
            zdiv1_p5_o    <= 1'b0;
            busy_o        <= 1'b0;
            locked_o      <= 1'b0;
            done_o        <= 1'b0;
            err_cfg_o     <= 1'b0;
            err_timeout_o <= 1'b0;
            err_lol_o     <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            err_cfg_o <= 1'b0;
            if (accepting && req_i && cfg_valid) begin
                sh_ratio_q    <= cfg_ratio_i;
                sh_fraction_q <= cfg_fraction_i;
                sh_mdiv_q     <= cfg_mdiv_i;
                sh_vcodiv_q   <= cfg_vcodiv_i;
                sh_zdiv0_q    <= cfg_zdiv0_i;
                sh_zdiv0_p5_q <= cfg_zdiv0_p5_i;
                sh_zdiv1_q    <= cfg_zdiv1_i;
                sh_zdiv1_p5_q <= cfg_zdiv1_p5_i;
                err_timeout_o <= 1'b0;
                err_lol_o     <= 1'b0;
                off_cnt_q     <= '0;
                pllen_o       <= 1'b0;
                bypass_o      <= 1'b1;
                busy_o        <= 1'b1;
                locked_o      <= 1'b0;
                state_q       <= StPwrDown;
            end else begin
                if (accepting && req_i) begin
                    err_cfg_o <= 1'b1;
                end
                unique case (state_q)
                    StPwrDown: begin
                        if (off_cnt_q == OffW'(OFF_CYCLES - 1)) begin
                            state_q <= StLoad;
                        end else begin
                            off_cnt_q <= off_cnt_q + OffW'(1);
                        end
                    end
                    StLoad: begin
                        // Dividers only move here, while pllen_o is still low.
                        ratio_o    <= sh_ratio_q;
                        fraction_o <= sh_fraction_q;
                        mdiv_o     <= sh_mdiv_q;
                        vcodiv_o   <= sh_vcodiv_q;
                        zdiv0_o    <= sh_zdiv0_q;
                        zdiv0_p5_o <= sh_zdiv0_p5_q;
                        zdiv1_o    <= sh_zdiv1_q;
                        zdiv1_p5_o <= sh_zdiv1_p5_q;
                        stab_cnt_q <= '0;
                        to_cnt_q   <= '0;
                        pllen_o    <= 1'b1;
                        state_q    <= StPwrUp;
                    end
                    StPwrUp: begin
                        if (!lock_s) begin
                            stab_cnt_q <= '0;
                        end else if (stab_cnt_q != StabW'(LOCK_STABLE)) begin
                            stab_cnt_q <= stab_cnt_q + StabW'(1);
                        end
                        if (to_cnt_q != ToW'(LOCK_TIMEOUT)) begin
                            to_cnt_q <= to_cnt_q + ToW'(1);
                        end
                        // Lock qualification takes priority over a coincident timeout.
                        if (stab_cnt_q == StabW'(LOCK_STABLE)) begin
                            bypass_o <= 1'b0;
                            locked_o <= 1'b1;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                            state_q  <= StLocked;
                        end else if (to_cnt_q == ToW'(LOCK_TIMEOUT - 1)) begin
                            pllen_o       <= 1'b0;
                            busy_o        <= 1'b0;
                            err_timeout_o <= 1'b1;
                            state_q       <= StError;
                        end
                    end
                    StLocked: begin
                        if (!lock_s) begin
                            bypass_o  <= 1'b1;
                            locked_o  <= 1'b0;
                            err_lol_o <= 1'b1;
                            state_q   <= StError;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pll_cfg_seq.sv
// Directed bench for pll_cfg_seq with OFF_CYCLES=4, LOCK_STABLE=3, LOCK_TIMEOUT=20.
// Cycle numbers in comments count from 1 = first cycle after the request cycle.
module tb_pll_cfg_seq;

    logic        clk;
    logic        rst_ni;
    logic        req;
    logic [9:0]  cfg_ratio;
    logic [23:0] cfg_fraction;
    logic [5:0]  cfg_mdiv;
    logic [1:0]  cfg_vcodiv;
    logic [9:0]  cfg_zdiv0;
    logic        cfg_zdiv0_p5;
    logic [9:0]  cfg_zdiv1;
    logic        cfg_zdiv1_p5;
    logic        lock;
    logic        pllen, bypass;
    logic [9:0]  ratio;
    logic [23:0] fraction;
    logic [5:0]  mdiv;
    logic [1:0]  vcodiv;
    logic [9:0]  zdiv0;
    logic        zdiv0_p5;
    logic [9:0]  zdiv1;
    logic        zdiv1_p5;
    logic        busy, locked, done, err_cfg, err_timeout, err_lol;

    int checks = 0;
    int errors = 0;

    pll_cfg_seq #(
        .OFF_CYCLES  (4),
        .LOCK_STABLE (3),
        .LOCK_TIMEOUT(20)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .req_i         (req),
        .cfg_ratio_i   (cfg_ratio),
        .cfg_fraction_i(cfg_fraction),
        .cfg_mdiv_i    (cfg_mdiv),
        .cfg_vcodiv_i  (cfg_vcodiv),
        .cfg_zdiv0_i   (cfg_zdiv0),
        .cfg_zdiv0_p5_i(cfg_zdiv0_p5),
        .cfg_zdiv1_i   (cfg_zdiv1),
        .cfg_zdiv1_p5_i(cfg_zdiv1_p5),
        .lock_i        (lock),
        .pllen_o       (pllen),
        .bypass_o      (bypass),
        .ratio_o       (ratio),
        .fraction_o    (fraction),
        .mdiv_o        (mdiv),
        .vcodiv_o      (vcodiv),
        .zdiv0_o       (zdiv0),
        .zdiv0_p5_o    (zdiv0_p5),
        .zdiv1_o       (zdiv1),
        .zdiv1_p5_o    (zdiv1_p5),
        .busy_o        (busy),
        .locked_o      (locked),
        .done_o        (done),
        .err_cfg_o     (err_cfg),
        .err_timeout_o (err_timeout),
        .err_lol_o     (err_lol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a one-cycle request; returns in cycle 1 after the request.
    task automatic request(input logic [9:0] r, input logic [5:0] m, input logic [23:0] f);
        cfg_ratio    = r;
        cfg_mdiv     = m;
        cfg_fraction = f;
        req          = 1'b1;
        tick();
        req = 1'b0;
    endtask

    initial begin
        rst_ni       = 1'b0;
        req          = 1'b0;
        lock         = 1'b0;
        cfg_ratio    = '0;
        cfg_fraction = '0;
        cfg_mdiv     = '0;
        cfg_vcodiv   = '0;
        cfg_zdiv0    = '0;
        cfg_zdiv0_p5 = 1'b0;
        cfg_zdiv1    = '0;
        cfg_zdiv1_p5 = 1'b0;
        tick(2);
        chk("rst_pllen", 32'(pllen), 0);
        chk("rst_bypass", 32'(bypass), 1);
        chk("rst_ratio", 32'(ratio), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_errs", {29'd0, err_cfg, err_timeout, err_lol}, 0);
        rst_ni = 1'b1;
        tick(2);

        // Rejection in IDLE: ratio 0
        request(10'd0, 6'd5, 24'd0);
        chk("rej_idle_pulse", 32'(err_cfg), 1);
        chk("rej_idle_busy", 32'(busy), 0);
        chk("rej_idle_bypass", 32'(bypass), 1);
        chk("rej_idle_pllen", 32'(pllen), 0);
        tick();
        chk("rej_idle_pulse_end", 32'(err_cfg), 0);
        chk("rej_idle_state", 32'(busy), 0);

        // Nominal: lock rises on PWR_UP entry, LOCKED at 6+2+3+1 = 12
        cfg_vcodiv   = 2'd1;
        cfg_zdiv0    = 10'd5;
        cfg_zdiv0_p5 = 1'b1;
        cfg_zdiv1    = 10'd7;
        cfg_zdiv1_p5 = 1'b0;
        request(10'd100, 6'd2, 24'h123456);
        chk("nom_c1_busy", 32'(busy), 1);
        chk("nom_c1_pllen", 32'(pllen), 0);
        chk("nom_c1_bypass", 32'(bypass), 1);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk("nom_off_pllen", 32'(pllen), 0);
            chk("nom_off_ratio", 32'(ratio), 0);
        end
        tick();
        chk("nom_c6_ratio", 32'(ratio), 100);
        chk("nom_c6_fraction", 32'(fraction), 32'h123456);
        chk("nom_c6_mdiv", 32'(mdiv), 2);
        chk("nom_c6_vcodiv", 32'(vcodiv), 1);
        chk("nom_c6_zdiv", {zdiv0_p5, zdiv0, zdiv1_p5, zdiv1}, {1'b1, 10'd5, 1'b0, 10'd7});
        chk("nom_c6_pllen", 32'(pllen), 1);
        chk("nom_c6_bypass", 32'(bypass), 1);
        lock = 1'b1;
        for (int c = 7; c <= 11; c++) begin
            tick();
            chk("nom_wait_locked", 32'(locked), 0);
            chk("nom_wait_bypass", 32'(bypass), 1);
        end
        tick();
        chk("nom_c12_done", 32'(done), 1);
        chk("nom_c12_bypass", 32'(bypass), 0);
        chk("nom_c12_locked", 32'(locked), 1);
        chk("nom_c12_busy", 32'(busy), 0);
        tick();
        chk("nom_c13_done", 32'(done), 0);
        chk("nom_c13_locked", 32'(locked), 1);

        // Loss of lock: lock_i low in cycle 13 only, ERROR seen in cycle 16
        lock = 1'b0;
        tick();
        lock = 1'b1;
        chk("lol_c14_locked", 32'(locked), 1);
        tick();
        chk("lol_c15_bypass", 32'(bypass), 0);
        tick();
        chk("lol_flag", 32'(err_lol), 1);
        chk("lol_bypass", 32'(bypass), 1);
        chk("lol_pllen", 32'(pllen), 1);
        chk("lol_locked", 32'(locked), 0);
        chk("lol_no_timeout", 32'(err_timeout), 0);

        // Re-request from ERROR, lock already stable: LOCKED at 6+3+1 = 10
        request(10'd200, 6'd3, 24'd0);
        chk("rereq_lol_clear", 32'(err_lol), 0);
        chk("rereq_busy", 32'(busy), 1);
        chk("rereq_pllen", 32'(pllen), 0);
        tick(5);
        chk("rereq_c6_ratio", 32'(ratio), 200);
        chk("rereq_c6_mdiv", 32'(mdiv), 3);
        // Request during PWR_UP must be ignored entirely
        cfg_ratio = 10'd0;
        cfg_mdiv  = 6'd1;
        req       = 1'b1;
        tick();
        req = 1'b0;
        chk("ign_no_pulse", 32'(err_cfg), 0);
        chk("ign_busy", 32'(busy), 1);
        chk("ign_shadow", 32'(dut.sh_ratio_q), 200);
        tick(2);
        chk("rereq_c9_locked", 32'(locked), 0);
        tick();
        chk("rereq_c10_locked", 32'(locked), 1);
        chk("rereq_c10_done", 32'(done), 1);
        chk("rereq_c10_ratio", 32'(ratio), 200);

        // Rejection in LOCKED: mdiv 0
        request(10'd300, 6'd0, 24'd0);
        chk("rej_lock_pulse", 32'(err_cfg), 1);
        chk("rej_lock_locked", 32'(locked), 1);
        chk("rej_lock_ratio", 32'(ratio), 200);
        tick();
        chk("rej_lock_pulse_end", 32'(err_cfg), 0);

        // Glitch: lock_i high 6-7, low 8, high 9+ -> lock_s high 8-9, low 10, high 11+
        lock = 1'b0;
        request(10'd300, 6'd4, 24'd0);
        tick(5);
        chk("gl_c6_ratio", 32'(ratio), 300);
        lock = 1'b1;
        tick(2);
        lock = 1'b0;
        tick();
        lock = 1'b1;
        tick(5);
        chk("gl_c14_locked", 32'(locked), 0);
        tick();
        chk("gl_c15_locked", 32'(locked), 1);
        chk("gl_c15_done", 32'(done), 1);

        // Timeout: PWR_UP entered at cycle 6, ERROR at 26
        lock = 1'b0;
        request(10'd400, 6'd6, 24'd0);
        tick(5);
        chk("to_c6_ratio", 32'(ratio), 400);
        tick(19);
        chk("to_c25_busy", 32'(busy), 1);
        chk("to_c25_flag", 32'(err_timeout), 0);
        tick();
        chk("to_flag", 32'(err_timeout), 1);
        chk("to_pllen", 32'(pllen), 0);
        chk("to_bypass", 32'(bypass), 1);
        chk("to_busy", 32'(busy), 0);
        chk("to_no_lol", 32'(err_lol), 0);
        chk("to_ratio_hold", 32'(ratio), 400);
        // Rejection in ERROR leaves the sticky flag alone
        request(10'd9, 6'd0, 24'd0);
        chk("rej_err_pulse", 32'(err_cfg), 1);
        chk("rej_err_sticky", 32'(err_timeout), 1);
        chk("rej_err_pllen", 32'(pllen), 0);

        // Asynchronous reset during PWR_UP
        request(10'd500, 6'd7, 24'd0);
        chk("ar_to_clear", 32'(err_timeout), 0);
        tick(5);
        chk("ar_c6_ratio", 32'(ratio), 500);
        chk("ar_c6_pllen", 32'(pllen), 1);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("ar_pllen", 32'(pllen), 0);
        chk("ar_bypass", 32'(bypass), 1);
        chk("ar_ratio", 32'(ratio), 0);
        chk("ar_mdiv", 32'(mdiv), 0);
        chk("ar_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        tick(3);
        chk("ar_idle_busy", 32'(busy), 0);
        chk("ar_idle_bypass", 32'(bypass), 1);
        chk("ar_idle_pllen", 32'(pllen), 0);
        chk("ar_idle_locked", 32'(locked), 0);
        chk("ar_idle_shadow", 32'(dut.sh_ratio_q), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
